execute_mdu: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage; implements the RV64M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W variants) over several cycles. Replaces the single-cycle ALU path for M-extension instructions. The execute stage holds its instruction and raises its stall while this block is busy. A valid/ready handshake on both sides lets the downstream memory-stage stall back-pressure a finished result.

---
 rtl/execute_mdu.sv | 197 +++++++++++++++++++
 tb/tb_execute_mdu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mdu.sv
// ----------------------------------------------------------------------------
// execute_mdu
//   Iterative RV64M multiply/divide unit for the execute stage. Multiplies by
//   radix-2 shift-add and divides by restoring division, one bit per cycle,
//   on operand magnitudes. A final FIX cycle applies sign correction and picks
//   the result. Divide-by-zero and signed overflow take a short fast path.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   flush      in   synchronous abort of any in-flight or held operation
//   in_valid   in   operation request
//   in_ready   out  high only while idle
//   in_op      in   funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   in_word    in   32-bit W variant, result sign-extended to XLEN
//   in_srca    in   rs1 operand
//   in_srcb    in   rs2 operand
//   out_valid  out  result available (held until out_ready)
//   out_ready  in   consumer takes the result
//   out_result out  result
// ----------------------------------------------------------------------------
module execute_mdu #(
    parameter int XLEN     = 64,
    parameter bit HAS_WORD = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_srca,
    input  logic [XLEN-1:0] in_srcb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);
    // Word ops are meaningless on a 32-bit core.
    localparam bit WORD_EN = (XLEN == 32) ? 1'b0 : HAS_WORD;
    localparam int CW      = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic            r_word, r_neg_a, r_neg_b, r_fast;
    logic [XLEN-1:0] r_hi, r_lo, r_b, r_result;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic signed [31:0] t;
        t = x;
        return XLEN'(t);
    endfunction

    // ---------------- accept-time decode ----------------
    logic            w_word, w_sa, w_sb, w_neg_a, w_neg_b;
    logic            w_div_zero, w_ovf, w_fast;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_mag_a, w_mag_b, w_dividend, w_fast_res;

    assign w_word  = in_word & WORD_EN;
    assign w_sa    = (in_op == 3'd1) | (in_op == 3'd2) | (in_op == 3'd4) | (in_op == 3'd6);
    assign w_sb    = (in_op == 3'd1) | (in_op == 3'd4) | (in_op == 3'd6);
    assign w_a_ext = !w_word ? in_srca : (w_sa ? sext32(in_srca[31:0]) : XLEN'(in_srca[31:0]));
    assign w_b_ext = !w_word ? in_srcb : (w_sb ? sext32(in_srcb[31:0]) : XLEN'(in_srcb[31:0]));
    assign w_neg_a = w_sa & w_a_ext[XLEN-1];
    assign w_neg_b = w_sb & w_b_ext[XLEN-1];
    assign w_mag_a = w_neg_a ? -w_a_ext : w_a_ext;
    assign w_mag_b = w_neg_b ? -w_b_ext : w_b_ext;

    assign w_div_zero = in_op[2] & (w_word ? (in_srcb[31:0] == 32'd0) : (in_srcb == '0));
    assign w_ovf      = in_op[2] & w_sa &
                        (w_word ? (in_srca[31:0] == 32'h8000_0000) && (&in_srcb[31:0])
                                : (in_srca == {1'b1, {(XLEN-1){1'b0}}}) && (&in_srcb));
    assign w_fast     = w_div_zero | w_ovf;

    // Fast-path result is final at accept time; it is parked in r_lo.
    assign w_dividend = w_word ? sext32(in_srca[31:0]) : in_srca;
    assign w_fast_res = in_op[1] ? (w_div_zero ? w_dividend : '0)
                                 : (w_div_zero ? '1 : w_dividend);

    // ---------------- iteration datapath ----------------
    logic [XLEN:0] w_sum, w_rem_sh, w_diff;
    logic          w_qbit;

    assign w_sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_qbit   = ~w_diff[XLEN];

    // ---------------- fix-up / result selection ----------------
    // A word multiply runs only 32 steps, so the product sits 32 bits up in
    // {r_hi, r_lo}; shift it back before applying the sign.
    logic [2*XLEN-1:0] w_prod_raw, w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_mulh, w_sel, w_fix_res;
    logic              w_neg;

    assign w_neg      = r_neg_a ^ r_neg_b;
    assign w_prod_raw = r_word ? ({r_hi, r_lo} >> (XLEN - 32)) : {r_hi, r_lo};
    assign w_prod     = w_neg ? -w_prod_raw : w_prod_raw;
    assign w_mulh     = r_word ? XLEN'(w_prod[63:32]) : w_prod[2*XLEN-1:XLEN];
    assign w_quot     = w_neg ? -r_lo : r_lo;
    assign w_rem      = r_neg_a ? -r_hi : r_hi;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_sel = w_prod[XLEN-1:0];
        case (r_op)
            3'd1, 3'd2, 3'd3: w_sel = w_mulh;
            3'd4, 3'd5:       w_sel = w_quot;
            3'd6, 3'd7:       w_sel = w_rem;
            default:          w_sel = w_prod[XLEN-1:0];
        endcase
    end

    assign w_fix_res = r_fast ? r_lo : (r_word ? sext32(w_sel[31:0]) : w_sel);

    // ---------------- control FSM ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = BUSY;
            BUSY:    if (r_cnt == CW'(1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the datapath is a handful of flops, not a memory, so all of it
        // is reset; a reset mid-operation never exposes stale data.
        if (!reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_word   <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_fast   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op    <= in_op;
                    r_word  <= w_word;
                    r_neg_a <= w_neg_a;
                    r_neg_b <= w_neg_b;
                    r_fast  <= w_fast;
                    r_b     <= w_mag_b;
                    r_hi    <= '0;
                    // Fast path spends one pass-through cycle so its result
                    // appears two cycles after accept.
                    r_cnt   <= w_fast ? CW'(1) : (w_word ? CW'(32) : CW'(XLEN));
                    if (w_fast)
                        r_lo <= w_fast_res;
                    else if (in_op[2] && w_word)
                        r_lo <= w_mag_a << (XLEN - 32);  // MSB-first divide starts at bit 31
                    else
                        r_lo <= w_mag_a;
                end
                BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (!r_fast) begin
                        if (r_op[2]) begin
                            r_hi <= w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_qbit};
                        end else begin
                            {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
                        end
                    end
                end
                FIX:     r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;

endmodule

// File: tb/tb_execute_mdu.sv
module tb_execute_mdu;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_word, out_ready;
    logic [2:0]  in_op;
    logic [63:0] in_srca, in_srcb;
    logic        in_ready, out_valid;
    logic [63:0] out_result;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    execute_mdu #(.XLEN(64), .HAS_WORD(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_word   (in_word),
        .in_srca   (in_srca),
        .in_srcb   (in_srcb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: extend operands to their true integer values, do the
    // arithmetic in wide signed math, then truncate / sign-extend.
    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input bit w,
                                            input logic [63:0] a, input logic [63:0] b);
        int n;
        bit sa, sb;
        logic [63:0] av, bv, res;
        logic signed [129:0] x, y, p, q, r, mn;
        logic [129:0] u;
        n  = w ? 32 : 64;
        av = w ? {32'b0, a[31:0]} : a;
        bv = w ? {32'b0, b[31:0]} : b;
        sa = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sb = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        x = {66'b0, av};
        y = {66'b0, bv};
        if (sa && av[n-1]) x = x - (130'sd1 <<< n);
        if (sb && bv[n-1]) y = y - (130'sd1 <<< n);
        if (!op[2]) begin
            p   = x * y;
            u   = p;
            res = (op == 3'd0) ? u[63:0] : 64'(u >> n);
        end else begin
            mn = -(130'sd1 <<< (n - 1));
            if (y == '0) begin
                q = '1;
                r = x;
            end else if (sa && x == mn && y == '1) begin
                q = x;
                r = '0;
            end else begin
                q = x / y;
                r = x % y;
            end
            u   = op[1] ? r : q;
            res = u[63:0];
        end
        if (w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input bit w,
                                   input logic [63:0] a, input logic [63:0] b);
        bit bz, ov;
        bz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ov = (op == 3'd4 || op == 3'd6) &&
             (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MINV && b == ALL1));
        return op[2] && (bz || ov);
    endfunction

    // Called 1 ns after a rising edge with the DUT idle.
    task automatic start_op(input logic [2:0] op, input bit w,
                            input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_word  = w;
        in_srca  = a;
        in_srcb  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input bit w,
                          input logic [63:0] a, input logic [63:0] b);
        int lat, exp_lat;
        exp_lat = is_fast(op, w, a, b) ? 2 : (w ? 33 : 65);
        check({tag, " ready"}, 64'(in_ready), 64'd1);
        start_op(op, w, a, b);
        wait_valid(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, out_result, ref_mdu(op, w, a, b));
        @(posedge clk); #1;
        check({tag, " back to idle"}, 64'(in_ready), 64'd1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return ALL1;
            2:       return MINV;
            3:       return 64'($urandom_range(0, 20));
            4:       return {32'($urandom), 32'h8000_0000 | 32'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        int lat;
        bit seen, stable;
        logic [63:0] held, exp_held;
        logic [2:0] rop;
        bit rw;
        logic [63:0] ra, rb;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_word = 1'b0;
        in_srca = '0; in_srcb = '0; out_ready = 1'b1;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_result", out_result, 64'd0);
        #21 reset = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        // Multiplies
        run_op("MUL 7*-3",      3'd0, 1'b0, 64'd7, -64'sd3);
        check("MUL 7*-3 value", ref_mdu(3'd0, 1'b0, 64'd7, -64'sd3), 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("MULH 7*-3",     3'd1, 1'b0, 64'd7, -64'sd3);
        run_op("MULHU max*2",   3'd3, 1'b0, ALL1, 64'd2);
        run_op("MULHSU -1*2",   3'd2, 1'b0, ALL1, 64'd2);
        // Divides
        run_op("DIV -7/2",      3'd4, 1'b0, -64'sd7, 64'd2);
        run_op("REM -7/2",      3'd6, 1'b0, -64'sd7, 64'd2);
        run_op("DIVU 100/7",    3'd5, 1'b0, 64'd100, 64'd7);
        run_op("REMU 100/7",    3'd7, 1'b0, 64'd100, 64'd7);
        run_op("DIVW",          3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'd1);
        run_op("MULW",          3'd0, 1'b1, 64'h1234_0000_7FFF_FFFF, 64'hABCD_0000_0000_0003);
        // Fast paths
        run_op("DIV 5/0",       3'd4, 1'b0, 64'd5, 64'd0);
        run_op("REM 5/0",       3'd6, 1'b0, 64'd5, 64'd0);
        run_op("DIV min/-1",    3'd4, 1'b0, MINV, ALL1);
        run_op("REM min/-1",    3'd6, 1'b0, MINV, ALL1);
        run_op("REMUW x/0",     3'd7, 1'b1, 64'h0000_0000_9000_0001, 64'hFFFF_FFFF_0000_0000);
        run_op("DIVW min/-1",   3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        exp_held  = ref_mdu(3'd5, 1'b0, 64'd1_000_003, 64'd17);
        start_op(3'd5, 1'b0, 64'd1_000_003, 64'd17);
        wait_valid(lat);
        check("bp latency", 64'(lat), 64'd65);
        check("bp result", out_result, exp_held);
        held   = out_result;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || out_result !== held || in_ready) stable = 1'b0;
        end
        check("bp held stable", 64'(stable), 64'd1);
        check("bp in_ready low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release idle", 64'(in_ready), 64'd1);
        check("bp release valid", 64'(out_valid), 64'd0);
        run_op("after bp REM", 3'd6, 1'b0, 64'd1000, -64'sd33);

        // Flush mid-BUSY.
        start_op(3'd1, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        repeat (19) begin @(posedge clk); #1; end
        check("flush busy before", 64'(in_ready), 64'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy idle", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush busy no valid", 64'(seen), 64'd0);

        // Flush wins over accept in IDLE.
        in_valid = 1'b1; in_op = 3'd4; in_word = 1'b0; in_srca = 64'd5; in_srcb = 64'd0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush idle no accept", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush idle no valid", 64'(seen), 64'd0);

        // Asynchronous reset mid-BUSY (out_result still holds a nonzero result).
        run_op("pre-reset MUL", 3'd0, 1'b0, 64'd12345, 64'd678);
        start_op(3'd4, 1'b0, -64'sd1000, 64'd7);
        repeat (10) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        check("async reset valid", 64'(out_valid), 64'd0);
        check("async reset result", out_result, 64'd0);
        check("async reset ready", 64'(in_ready), 64'd1);
        #10 reset = 1'b1;
        @(posedge clk); #1;
        check("reset release ready", 64'(in_ready), 64'd1);
        check("reset release valid", 64'(out_valid), 64'd0);
        run_op("post-reset DIV", 3'd4, 1'b0, -64'sd1000, 64'd7);

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            rw  = 1'($urandom_range(0, 1));
            ra  = pick();
            rb  = pick();
            run_op($sformatf("rand%0d op%0d w%0d", i, rop, rw), rop, rw, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
